wb_stage: RTL
=============

// Module: wb_stage
// PURPOSE
//  Write-back stage: consumes the MEM/WB pipeline register outputs (wr_*), forms the register-file write port,
//  sign/zero-extends sub-word loads, and owns the architectural HI/LO registers (mult, mthi, mtlo).
//  Sits between the MEM/WB register and the register file / HI-LO read path of the ID/EX stages.
// PARAMETERS
//  DW      32   datapath width (fixed 32; parameter for readability only)
//  RSTV    0    reset value of HI and LO
// PORTS
//  clk            in   1   rising-edge clock
//  rst            in   1   reset, asynchronous, active-high
//  wr_dout        in   32  raw word read from data memory
//  wr_result      in   32  ALU result / memory address (bits[1:0] = byte offset for loads)
//  wr_HL          in   32  HI or LO value selected upstream (mfhi/mflo)
//  wr_mult        in   64  multiplier product {hi,lo}
//  wr_busA_mux2   in   32  rs operand (source for mthi/mtlo)
//  wr_rw          in   5   destination register
//  wr_regWr       in   1   register-file write enable
//  wr_multWr      in   1   write HI/LO from wr_mult
//  wr_Highin      in   1   mthi: HI <= wr_busA_mux2
//  wr_Lowin       in   1   mtlo: LO <= wr_busA_mux2
//  wr_memtoreg    in   2   writeback source select
//  wr_op          in   6   opcode (selects load width/sign)
//  rf_we          out  1   register-file write enable
//  rf_waddr       out  5   register-file write address
//  rf_wdata       out  32  register-file write data
//  hi_q / lo_q    out  32  architectural HI / LO (registered)
//  hi_fwd/lo_fwd  out  32  next-value HI / LO (bypass to EX for back-to-back mult->mfhi)
// BEHAVIOUR
//  - Reset (async, rst=1): hi_q=lo_q=RSTV immediately; all other outputs are combinational from wr_*.
//  - rf_we = wr_regWr & (wr_rw != 0); rf_waddr = wr_rw; write to $0 is always suppressed. Zero latency.
//  - wr_memtoreg: 00 wr_result; 01 load data (below); 10 wr_HL; 11 wr_result (reserved, treated as 00).
//  - Load data by wr_op, off=wr_result[1:0], little-endian byte lanes:
//    0x20 lb sext byte[off]; 0x24 lbu zext byte[off]; 0x21 lh sext half[off[1]]; 0x25 lhu zext half[off[1]];
//    0x23 lw and any other op: wr_dout unchanged. off[0] ignored for halfwords (alignment checked upstream).
//  - HI/LO update on rising clk, priority: wr_multWr (HI<=mult[63:32], LO<=mult[31:0]) overrides
//    wr_Highin / wr_Lowin; Highin and Lowin together update both from wr_busA_mux2.
//  - hi_fwd/lo_fwd = value hi_q/lo_q will take at next edge (equals hi_q/lo_q when no update pending).
//  - rst asserted mid-operation: pending HI/LO update is discarded; first edge after release behaves normally.
// CONFIGURATION
//  WB_PERF_EN defined: adds outputs retire_cnt[31:0], hilo_wr_cnt[31:0]; retire_cnt increments on each
//   clk with (rf_we | wr_multWr | wr_Highin | wr_Lowin); hilo_wr_cnt on each HI/LO update; both wrap
//   32'hFFFFFFFF->0, reset to 0. Not defined: ports and counters absent, no other change.
// STRUCTURE
//  Shared package pipe_pkg: opcode constants OP_LB/LBU/LH/LHU/LW, MEMTOREG_* encodings, hilo_t typedef.
//  One sub-module: wb_load_ext (pure combinational byte/half select and extension).
// TESTING
//  1 rst=1 mid-run with wr_multWr=1 -> hi_q=lo_q=0 immediately, no update at next edge.
//  2 lb, wr_dout=32'h80FF_7F01, off=3 -> rf_wdata=32'hFFFF_FF80; lbu off=2 -> 32'h0000_00FF.
//  3 lh off=2, same dout -> 32'hFFFF_80FF; lhu off=0 -> 32'h0000_7F01.
//  4 wr_regWr=1, wr_rw=0 -> rf_we=0; wr_rw=5 -> rf_we=1, rf_waddr=5.
//  5 wr_multWr=1, wr_Highin=1, mult=64'h1234_5678_9ABC_DEF0, busA=32'hDEAD -> hi_q=32'h1234_5678,
//    lo_q=32'h9ABC_DEF0 after edge; hi_fwd shows 32'h1234_5678 in same cycle.
//  6 WB_PERF_EN: 10 retiring cycles, counter preset near 32'hFFFF_FFFE -> wraps to 8; absent build compiles clean.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: load opcodes, writeback source encodings, HI/LO pair type.
package pipe_pkg;
  localparam int DW = 32;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;

  localparam logic [1:0] MEMTOREG_ALU  = 2'b00;
  localparam logic [1:0] MEMTOREG_LOAD = 2'b01;
  localparam logic [1:0] MEMTOREG_HL   = 2'b10;
  localparam logic [1:0] MEMTOREG_RSV  = 2'b11;

  typedef struct packed {
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
  } hilo_t;
endpackage

// File: rtl/wb_load_ext.sv
// Sub-word load select and extension. Purely combinational.
// Little-endian byte lanes; off[0] is ignored for halfword loads.
module wb_load_ext
  import pipe_pkg::*;
(
  input  logic [5:0]    op,
  input  logic [DW-1:0] dout,
  input  logic [1:0]    off,
  output logic [DW-1:0] ldata
);
  logic [3:0][7:0]  lanes;
  logic [1:0][15:0] halves;
  logic [7:0]       bsel;
  logic [15:0]      hsel;

  assign lanes  = dout;
  assign halves = dout;
  assign bsel   = lanes[off];
  assign hsel   = halves[off[1]];

  // Pick the lane and extend according to the opcode; unknown ops pass the word through
  always_comb begin
    ldata = dout;
    unique case (op)
      OP_LB:   ldata = {{24{bsel[7]}}, bsel};
      OP_LBU:  ldata = {24'h0, bsel};
      OP_LH:   ldata = {{16{hsel[15]}}, hsel};
      OP_LHU:  ldata = {16'h0, hsel};
      default: ldata = dout;
    endcase
  end
endmodule

// File: rtl/wb_stage.sv
// Write-back stage: register-file write port, sub-word load extension, HI/LO registers.
// Optional WB_PERF_EN adds retire_cnt / hilo_wr_cnt performance counters.
module wb_stage
  import pipe_pkg::*;
#(
  parameter int          DW_P = 32,
  parameter logic [31:0] RSTV = 32'h0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   wr_dout,
  input  logic [31:0]   wr_result,
  input  logic [31:0]   wr_HL,
  input  logic [63:0]   wr_mult,
  input  logic [31:0]   wr_busA_mux2,
  input  logic [4:0]    wr_rw,
  input  logic          wr_regWr,
  input  logic          wr_multWr,
  input  logic          wr_Highin,
  input  logic          wr_Lowin,
  input  logic [1:0]    wr_memtoreg,
  input  logic [5:0]    wr_op,
  output logic          rf_we,
  output logic [4:0]    rf_waddr,
  output logic [31:0]   rf_wdata,
  output logic [31:0]   hi_q,
  output logic [31:0]   lo_q,
  output logic [31:0]   hi_fwd,
  output logic [31:0]   lo_fwd
`ifdef WB_PERF_EN
  ,
  output logic [31:0]   retire_cnt,
  output logic [31:0]   hilo_wr_cnt
`endif
);
  logic [DW_P-1:0] ldata;
  hilo_t           hilo_r, hilo_n;
  logic            hilo_upd;

  wb_load_ext u_ext (
    .op    (wr_op),
    .dout  (wr_dout),
    .off   (wr_result[1:0]),
    .ldata (ldata)
  );

  // Register-file port; $0 is never written
  assign rf_we    = wr_regWr & (wr_rw != 5'd0);
  assign rf_waddr = wr_rw;

  // Writeback source select; the reserved encoding behaves like the ALU path
  always_comb begin
    rf_wdata = wr_result;
    unique case (wr_memtoreg)
      MEMTOREG_LOAD: rf_wdata = ldata;
      MEMTOREG_HL:   rf_wdata = wr_HL;
      default:       rf_wdata = wr_result;
    endcase
  end

  // Next HI/LO: multiply wins over mthi/mtlo
  always_comb begin
    hilo_n = hilo_r;
    if (wr_multWr) begin
      hilo_n.hi = wr_mult[63:32];
      hilo_n.lo = wr_mult[31:0];
    end else begin
      if (wr_Highin) hilo_n.hi = wr_busA_mux2;
      if (wr_Lowin)  hilo_n.lo = wr_busA_mux2;
    end
  end

  assign hilo_upd = wr_multWr | wr_Highin | wr_Lowin;

  // Architectural HI/LO state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) hilo_r <= '{hi: RSTV, lo: RSTV};
    else     hilo_r <= hilo_n;
  end

  assign hi_q   = hilo_r.hi;
  assign lo_q   = hilo_r.lo;
  assign hi_fwd = hilo_n.hi;
  assign lo_fwd = hilo_n.lo;

`ifdef WB_PERF_EN
  // Retirement and HI/LO write counters, free-running and wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt  <= '0;
      hilo_wr_cnt <= '0;
    end else begin
      if (rf_we | hilo_upd) retire_cnt  <= retire_cnt + 32'd1;
      if (hilo_upd)         hilo_wr_cnt <= hilo_wr_cnt + 32'd1;
    end
  end
`endif
endmodule
